// File: rtl/game_timer_ctrl.sv
// Whack-a-mole round controller: drives the seconds counter's enable/clear, syncs its
// value into the clk domain and reports time left plus round status.
module game_timer_ctrl #(
    parameter int unsigned GAME_SECONDS = 30,
    parameter int unsigned WARN_SECONDS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic [5:0] sec_in,
    output logic       cnt_enable,
    output logic       cnt_clear,
    output logic [5:0] time_left,
    output logic       playing,
    output logic       paused,
    output logic       game_over,
    output logic       warn
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEARING = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_PAUSE    = 3'd3;
    localparam logic [2:0] ST_OVER     = 3'd4;

    localparam logic [5:0] GAME_SEC = 6'(GAME_SECONDS);
    localparam logic [5:0] WARN_SEC = 6'(WARN_SECONDS);

    logic [5:0] sec_s1_q, sec_s2_q, sec_stable_q;
    logic [2:0] state_q, state_d;
    logic [5:0] time_left_q, time_left_d;
    logic       cnt_enable_q, cnt_clear_q;
    logic       playing_q, paused_q, game_over_q, warn_q, warn_d;

    // Two-flop sync; the stable copy only moves when two samples agree, so a
    // multi-bit value caught mid-transition never reaches the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_s1_q     <= 6'd0;
            sec_s2_q     <= 6'd0;
            sec_stable_q <= 6'd0;
        end else begin
            sec_s1_q <= sec_in;
            sec_s2_q <= sec_s1_q;
            if (sec_s2_q == sec_s1_q) begin
                sec_stable_q <= sec_s2_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEARING;
            end
            ST_CLEARING: begin
                if (sec_stable_q == 6'd0) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (sec_stable_q >= GAME_SEC) state_d = ST_OVER;
                else if (pause_toggle)        state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_toggle) state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (start) state_d = ST_CLEARING;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        time_left_d = GAME_SEC;
        case (state_d)
            ST_PLAY, ST_PAUSE: begin
                if (sec_stable_q < GAME_SEC) time_left_d = GAME_SEC - sec_stable_q;
                else                         time_left_d = 6'd0;
            end
            ST_OVER: time_left_d = 6'd0;
            default: time_left_d = GAME_SEC;
        endcase
        warn_d = (state_d == ST_PLAY) && (time_left_d != 6'd0) && (time_left_d <= WARN_SEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            time_left_q  <= GAME_SEC;
            cnt_enable_q <= 1'b0;
            cnt_clear_q  <= 1'b0;
            playing_q    <= 1'b0;
            paused_q     <= 1'b0;
            game_over_q  <= 1'b0;
            warn_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_left_q  <= time_left_d;
            cnt_enable_q <= (state_d == ST_PLAY);
            cnt_clear_q  <= (state_d == ST_CLEARING);
            playing_q    <= (state_d == ST_PLAY);
            paused_q     <= (state_d == ST_PAUSE);
            game_over_q  <= (state_d == ST_OVER);
            warn_q       <= warn_d;
        end
    end

    assign cnt_enable = cnt_enable_q;
    assign cnt_clear  = cnt_clear_q;
    assign time_left  = time_left_q;
    assign playing    = playing_q;
    assign paused     = paused_q;
    assign game_over  = game_over_q;
    assign warn       = warn_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: expected output vectors are queued as stimulus is
// driven and popped when the outputs are sampled, 1 ns after the clock edge.
module tb_game_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pause_toggle;
    logic [5:0] sec_in;
    logic       cnt_enable, cnt_clear, playing, paused, game_over, warn;
    logic [5:0] time_left;

    always #5 clk = ~clk;

    game_timer_ctrl #(.GAME_SECONDS(30), .WARN_SECONDS(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pause_toggle (pause_toggle),
        .sec_in       (sec_in),
        .cnt_enable   (cnt_enable),
        .cnt_clear    (cnt_clear),
        .time_left    (time_left),
        .playing      (playing),
        .paused       (paused),
        .game_over    (game_over),
        .warn         (warn)
    );

    typedef struct {
        string       name;
        logic [11:0] vec;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    // Packing order: enable, clear, time_left, playing, paused, game_over, warn.
    function automatic logic [11:0] mk(bit en, bit clr, int tl, bit pl, bit pa, bit go, bit wn);
        return {en, clr, 6'(tl), pl, pa, go, wn};
    endfunction

    function automatic logic [11:0] obs();
        return {cnt_enable, cnt_clear, time_left, playing, paused, game_over, warn};
    endfunction

    task automatic push(input string nm, input logic [11:0] v);
        exp_t x;
        x.name = nm;
        x.vec  = v;
        sb.push_back(x);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pause_toggle = 1'b0; sec_in = 6'd0;
        tick(2);
        push("reset_held", mk(0, 0, 30, 0, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        rst_n = 1'b1;
        tick(2);
        push("idle_after_reset", mk(0, 0, 30, 0, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
    endtask

    task automatic test_round();
        int n;
        int tl;
        start = 1'b1; tick(); start = 1'b0;
        push("clear_pulse", mk(0, 1, 30, 0, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        tick();
        push("play_entry", mk(1, 0, 30, 1, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        for (int s = 1; s < 30; s++) begin
            sec_in = 6'(s);
            tick(4);
            tl = 30 - s;
            push($sformatf("play_sec%0d", s), mk(1, 0, tl, 1, 0, 0, tl <= 5));
            e = sb.pop_front(); total++;
            if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        end
        sec_in = 6'd30;
        push("time_up", mk(0, 0, 0, 0, 0, 1, 0));
        n = 0;
        do begin tick(); n++; end while (!game_over && n < 8);
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        total++;
        if (n > 4) begin bad++; $display("FAIL over_latency got=%0d cycles want<=4", n); end
    endtask

    task automatic test_restart();
        int n;
        start = 1'b1; pause_toggle = 1'b1; tick(); start = 1'b0; pause_toggle = 1'b0;
        push("restart_clear", mk(0, 1, 30, 0, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        tick(3);
        push("clear_hold", mk(0, 1, 30, 0, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        sec_in = 6'd0;
        push("restart_play", mk(1, 0, 30, 1, 0, 0, 0));
        n = 0;
        do begin tick(); n++; end while (!playing && n < 10);
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        total++;
        if (n != 4) begin bad++; $display("FAIL clear_exit_latency got=%0d want=4", n); end
    endtask

    task automatic test_pause();
        sec_in = 6'd10;
        tick(4);
        push("pre_pause", mk(1, 0, 20, 1, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
        push("paused", mk(0, 0, 20, 0, 1, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        start = 1'b1; tick(); start = 1'b0;
        tick(3);
        push("pause_hold_start_ignored", mk(0, 0, 20, 0, 1, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
        push("resume", mk(1, 0, 20, 1, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        start = 1'b1; tick(); start = 1'b0;
        push("start_in_play_ignored", mk(1, 0, 20, 1, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
    endtask

    task automatic test_glitch();
        sec_in = 6'd5;
        tick(4);
        push("pre_glitch", mk(1, 0, 25, 1, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        sec_in = 6'd63; tick(); sec_in = 6'd6;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (game_over !== 1'b0 || playing !== 1'b1) begin
                bad++;
                $display("FAIL glitch_cycle%0d got go=%b pl=%b want go=0 pl=1", i, game_over, playing);
            end
        end
        push("post_glitch", mk(1, 0, 24, 1, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
    endtask

    task automatic test_over_priority();
        sec_in = 6'd30;
        tick(3);
        pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
        push("over_beats_pause", mk(0, 0, 0, 0, 0, 1, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; tick(); start = 1'b0;
        sec_in = 6'd0;
        tick(5);
        sec_in = 6'd12;
        tick(4);
        push("mid_play", mk(1, 0, 18, 1, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        #2 rst_n = 1'b0; sec_in = 6'd0;
        #1;
        push("async_reset_play", mk(0, 0, 30, 0, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        tick(2);
        rst_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        sec_in = 6'd40;
        tick(5);
        push("over_sat", mk(0, 0, 0, 0, 0, 1, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        #2 rst_n = 1'b0; sec_in = 6'd0;
        #1;
        push("async_reset_over", mk(0, 0, 30, 0, 0, 0, 0));
        e = sb.pop_front(); total++;
        if (obs() !== e.vec) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.vec); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round();
        test_restart();
        test_pause();
        test_glitch();
        test_over_priority();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
